// File: rtl/cpu_dbus_bridge_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | cpu_dbus_bridge_if                                                       |
// | CPU-side, SRAM-side and peripheral-side signals of the data bus bridge.  |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
interface cpu_dbus_bridge_if;
  logic        cpu_request;
  logic [31:0] cpu_address;
  logic        cpu_write;
  logic [3:0]  cpu_wstrb;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        cpu_ack;
  logic        sram_en;
  logic [13:0] sram_addr;
  logic [3:0]  sram_wen;
  logic [31:0] sram_wdata;
  logic [31:0] sram_rdata;
  logic        per_valid;
  logic [31:0] per_address;
  logic        per_write;
  logic [3:0]  per_wstrb;
  logic [31:0] per_wdata;
  logic        per_ready;
  logic [31:0] per_rdata;
  logic        err_clear;
  logic        bus_error;
  logic [31:0] err_address;

  // slave: the bridge itself; master: the surrounding CPU, SRAM and peripherals
  modport slave (
    input  cpu_request, cpu_address, cpu_write, cpu_wstrb, cpu_wdata,
           sram_rdata, per_ready, per_rdata, err_clear,
    output cpu_rdata, cpu_ack, sram_en, sram_addr, sram_wen, sram_wdata,
           per_valid, per_address, per_write, per_wstrb, per_wdata,
           bus_error, err_address
  );
  modport master (
    output cpu_request, cpu_address, cpu_write, cpu_wstrb, cpu_wdata,
           sram_rdata, per_ready, per_rdata, err_clear,
    input  cpu_rdata, cpu_ack, sram_en, sram_addr, sram_wen, sram_wdata,
           per_valid, per_address, per_write, per_wstrb, per_wdata,
           bus_error, err_address
  );
endinterface
`default_nettype wire

// File: rtl/cpu_dbus_bridge.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | cpu_dbus_bridge                                                          |
// | Routes CPU loads/stores to SRAM, peripheral bus or an error response.    |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
module cpu_dbus_bridge (
  input  logic              clock,
  input  logic              reset,
  cpu_dbus_bridge_if.slave  bus
);

  localparam logic [7:0] C_TIMEOUT_LAST = 8'd254;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SRAM    = 3'd1,
    PERIPH  = 3'd2,
    WAITACK = 3'd3,
    ERR     = 3'd4
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [7:0]  r_timeout;
  logic [31:0] r_per_address;
  logic        r_per_write;
  logic [3:0]  r_per_wstrb;
  logic [31:0] r_per_wdata;
  logic [31:0] r_rdata;
  logic        r_bus_error;
  logic [31:0] r_err_address;

  logic        w_ack;
  logic        w_accept;
  logic        w_hit_sram;
  logic        w_hit_per;
  logic        w_null;
  logic        w_timeout;
  logic        w_log;
  logic [31:0] w_log_addr;
  logic [31:0] w_rdata;

  assign w_ack      = (r_state == SRAM) || (r_state == WAITACK) || (r_state == ERR);
  // Gating with reset keeps the combinational SRAM strobe quiet while in reset
  assign w_accept   = reset && bus.cpu_request && ((r_state == IDLE) || w_ack);
  assign w_hit_sram = (bus.cpu_address[31:16] == 16'h0000);
  assign w_hit_per  = (bus.cpu_address[31:24] == 8'hE0);
  assign w_null     = bus.cpu_write && (bus.cpu_wstrb == 4'h0);
  assign w_timeout  = (r_state == PERIPH) && !bus.per_ready && (r_timeout == C_TIMEOUT_LAST);
  assign w_log      = w_timeout || (w_accept && !w_null && !w_hit_sram && !w_hit_per);
  assign w_log_addr = w_timeout ? r_per_address : bus.cpu_address;

  always_comb begin
    w_state_next = r_state;
    if (w_ack) w_state_next = IDLE;
    if ((r_state == PERIPH) && (bus.per_ready || w_timeout)) w_state_next = WAITACK;
    if (w_accept) begin
      if (w_null)          w_state_next = WAITACK;
      else if (w_hit_sram) w_state_next = SRAM;
      else if (w_hit_per)  w_state_next = PERIPH;
      else                 w_state_next = ERR;
    end
  end

  always_comb begin
    w_rdata = 32'h0;
    case (r_state)
      SRAM:    w_rdata = bus.sram_rdata;
      WAITACK: w_rdata = r_rdata;
      default: w_rdata = 32'h0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state       <= IDLE;
      r_timeout     <= 8'h00;
      r_per_address <= 32'h0;
      r_per_write   <= 1'b0;
      r_per_wstrb   <= 4'h0;
      r_per_wdata   <= 32'h0;
      r_rdata       <= 32'h0;
      r_bus_error   <= 1'b0;
      r_err_address <= 32'h0;
    end else begin
      r_state <= w_state_next;

      if (w_accept && (w_state_next == PERIPH)) begin
        r_per_address <= bus.cpu_address;
        r_per_write   <= bus.cpu_write;
        r_per_wstrb   <= bus.cpu_wstrb;
        r_per_wdata   <= bus.cpu_wdata;
        r_timeout     <= 8'h00;
      end else if ((r_state == PERIPH) && !bus.per_ready) begin
        r_timeout <= r_timeout + 8'd1;
      end

      // Zero-strobe stores and timeouts complete through WAITACK with zero data
      if (w_accept || w_timeout)
        r_rdata <= 32'h0;
      else if ((r_state == PERIPH) && bus.per_ready)
        r_rdata <= bus.per_rdata;

      // A new error outranks a simultaneous clear
      if (w_log && (!r_bus_error || bus.err_clear)) begin
        r_bus_error   <= 1'b1;
        r_err_address <= w_log_addr;
      end else if (bus.err_clear) begin
        r_bus_error <= 1'b0;
      end
    end
  end

  assign bus.sram_en     = w_accept && w_hit_sram && !w_null;
  assign bus.sram_addr   = bus.cpu_address[15:2];
  assign bus.sram_wen    = (bus.sram_en && bus.cpu_write) ? bus.cpu_wstrb : 4'h0;
  assign bus.sram_wdata  = bus.cpu_wdata;

  assign bus.per_valid   = (r_state == PERIPH);
  assign bus.per_address = r_per_address;
  assign bus.per_write   = r_per_write;
  assign bus.per_wstrb   = r_per_wstrb;
  assign bus.per_wdata   = r_per_wdata;

  assign bus.cpu_ack     = w_ack;
  assign bus.cpu_rdata   = w_rdata;
  assign bus.bus_error   = r_bus_error;
  assign bus.err_address = r_err_address;

endmodule
`default_nettype wire

// File: tb/tb_cpu_dbus_bridge.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_cpu_dbus_bridge                                                       |
// | Vector table, directed corner cases and random traffic vs. a ref model.  |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
module tb_cpu_dbus_bridge;

  logic clock = 1'b0;
  logic rst_n = 1'b0;
  always #5 clock = ~clock;

  cpu_dbus_bridge_if bus ();
  cpu_dbus_bridge dut (.clock(clock), .reset(rst_n), .bus(bus));

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;

  // Reference model: outstanding transaction and sticky error, per the address map rules
  bit          m_busy = 1'b0;
  bit          m_pwait = 1'b0;
  int          m_wait = 0;
  int          m_ack_cyc = -1;
  bit          m_ack_sram = 1'b0;
  bit          m_chk_rd = 1'b0;
  logic [31:0] m_ack_rd = 32'h0;
  logic [31:0] m_pa = 32'h0, m_pd = 32'h0;
  bit          m_pw = 1'b0;
  logic [3:0]  m_ps = 4'h0;
  bit          m_err = 1'b0;
  logic [31:0] m_eaddr = 32'h0;

  bit          obs_ack, obs_en, obs_pv, obs_berr;
  logic [31:0] obs_rd, obs_eaddr;
  logic [13:0] obs_saddr;
  logic [3:0]  obs_wen;

  typedef struct {
    logic [31:0] addr;
    bit          wr;
    logic [3:0]  st;
    logic [31:0] wd;
    logic [31:0] data;
    int          lat;
    bit          clr;
    bit          x_en;
    logic [13:0] x_saddr;
    logic [3:0]  x_wen;
    int          x_delay;
    bit          x_chkrd;
    logic [31:0] x_rd;
    bit          x_err;
    logic [31:0] x_eaddr;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic cycle(input bit req, input logic [31:0] a, input bit wr, input logic [3:0] st,
                       input logic [31:0] wd, input bit clr, input bit rdy,
                       input logic [31:0] prd, input logic [31:0] srd);
    bit ack_now, acc, is_s, is_p, nul, pv, s_hit, log_e;
    logic [31:0] la;
    bus.cpu_request = req;  bus.cpu_address = a;  bus.cpu_write = wr;
    bus.cpu_wstrb   = st;   bus.cpu_wdata   = wd; bus.err_clear = clr;
    bus.per_ready   = rdy;  bus.per_rdata   = prd; bus.sram_rdata = srd;
    #1;
    ack_now = (m_ack_cyc == cyc);
    pv      = m_pwait;
    is_s    = (a[31:16] == 16'h0000);
    is_p    = (a[31:24] == 8'hE0);
    nul     = wr && (st == 4'h0);
    acc     = rst_n && req && (!m_busy || ack_now);
    s_hit   = acc && is_s && !nul;

    chk("cpu_ack", bus.cpu_ack, ack_now);
    if (!ack_now) chk("cpu_rdata_idle", bus.cpu_rdata, 32'h0);
    else if (m_chk_rd) chk("cpu_rdata", bus.cpu_rdata, m_ack_sram ? srd : m_ack_rd);
    chk("sram_en", bus.sram_en, s_hit);
    chk("sram_wen", bus.sram_wen, (s_hit && wr) ? st : 4'h0);
    if (s_hit) begin
      chk("sram_addr", bus.sram_addr, a[15:2]);
      chk("sram_wdata", bus.sram_wdata, wd);
    end
    chk("per_valid", bus.per_valid, pv);
    if (pv) begin
      chk("per_address", bus.per_address, m_pa);
      chk("per_write", bus.per_write, m_pw);
      chk("per_wstrb", bus.per_wstrb, m_ps);
      chk("per_wdata", bus.per_wdata, m_pd);
    end
    chk("bus_error", bus.bus_error, m_err);
    if (m_err) chk("err_address", bus.err_address, m_eaddr);

    obs_ack = bus.cpu_ack;   obs_rd = bus.cpu_rdata;  obs_en = bus.sram_en;
    obs_saddr = bus.sram_addr; obs_wen = bus.sram_wen; obs_pv = bus.per_valid;
    obs_berr = bus.bus_error; obs_eaddr = bus.err_address;

    if (!rst_n) begin
      m_busy = 1'b0; m_pwait = 1'b0; m_ack_cyc = -1; m_err = 1'b0; m_eaddr = 32'h0;
    end else begin
      log_e = 1'b0; la = 32'h0;
      if (ack_now) begin m_busy = 1'b0; m_ack_cyc = -1; end
      if (pv) begin
        if (rdy) begin
          m_pwait = 1'b0; m_ack_cyc = cyc + 1; m_ack_rd = prd; m_ack_sram = 1'b0; m_chk_rd = 1'b1;
        end else begin
          m_wait++;
          if (m_wait == 255) begin
            m_pwait = 1'b0; m_ack_cyc = cyc + 1; m_ack_rd = 32'h0; m_ack_sram = 1'b0;
            m_chk_rd = 1'b1; log_e = 1'b1; la = m_pa;
          end
        end
      end
      if (acc) begin
        m_busy = 1'b1;
        if (nul) begin
          m_ack_cyc = cyc + 1; m_ack_sram = 1'b0; m_chk_rd = 1'b0;
        end else if (is_s) begin
          m_ack_cyc = cyc + 1; m_ack_sram = 1'b1; m_chk_rd = 1'b1;
        end else if (is_p) begin
          m_pwait = 1'b1; m_wait = 0; m_pa = a; m_pw = wr; m_ps = st; m_pd = wd;
        end else begin
          m_ack_cyc = cyc + 1; m_ack_rd = 32'h0; m_ack_sram = 1'b0; m_chk_rd = 1'b1;
          log_e = 1'b1; la = a;
        end
      end
      if (log_e && (!m_err || clr)) begin m_err = 1'b1; m_eaddr = la; end
      else if (clr) m_err = 1'b0;
    end
    @(posedge clock); #1;
    cyc++;
  endtask

  task automatic idle(input bit clr);
    cycle(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, clr, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic apply_vec(input vec_t v);
    int d;
    bit got;
    cycle(1'b1, v.addr, v.wr, v.st, v.wd, v.clr, 1'b0, ~v.data, v.data);
    chk("vec sram_en", obs_en, v.x_en);
    if (v.x_en) chk("vec sram_addr", obs_saddr, v.x_saddr);
    chk("vec sram_wen", obs_wen, v.x_wen);
    d = 0; got = 1'b0;
    while (!got && d < 300) begin
      d++;
      cycle(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b0, (d == v.lat), (d == v.lat) ? v.data : ~v.data, v.data);
      got = obs_ack;
    end
    chk("vec ack_delay", got ? d : 0, v.x_delay);
    if (v.x_chkrd) chk("vec rdata", obs_rd, v.x_rd);
    chk("vec bus_error", obs_berr, v.x_err);
    if (v.x_err) chk("vec err_address", obs_eaddr, v.x_eaddr);
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] edges [4];
    int r;
    edges[0] = 32'h0000_FFFC; edges[1] = 32'h0001_0000;
    edges[2] = 32'hDFFF_FFFF; edges[3] = 32'hE100_0000;
    r = $urandom_range(0, 9);
    if (r < 4)      return {16'h0000, 16'($urandom)};
    else if (r < 7) return {8'hE0, 24'($urandom)};
    else if (r == 7) return edges[$urandom_range(0, 3)];
    else            return $urandom;
  endfunction

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    //          addr          wr st    wd            data          lat clr en saddr   wen  dly chk rd            err ea
    vecs[0] = '{32'h0000_0010, 0, 4'hF, 32'h0,        32'h1234_5678, 0, 0, 1, 14'h004,  4'h0, 1,  1, 32'h1234_5678, 0, 32'h0};
    vecs[1] = '{32'h0000_FFFC, 1, 4'h5, 32'hDEAD_BEEF, 32'h0BAD_F00D, 0, 0, 1, 14'h3FFF, 4'h5, 1,  1, 32'h0BAD_F00D, 0, 32'h0};
    vecs[2] = '{32'h0000_0020, 1, 4'h0, 32'h1111_1111, 32'h2222_2222, 0, 0, 0, 14'h000,  4'h0, 1,  0, 32'h0,         0, 32'h0};
    vecs[3] = '{32'hE000_0004, 1, 4'hF, 32'hA5A5_A5A5, 32'h1111_2222, 3, 0, 0, 14'h000,  4'h0, 4,  1, 32'h1111_2222, 0, 32'h0};
    vecs[4] = '{32'hE0FF_FFFC, 0, 4'hF, 32'h0,        32'hCAFE_F00D, 1, 0, 0, 14'h000,  4'h0, 2,  1, 32'hCAFE_F00D, 0, 32'h0};
    vecs[5] = '{32'h0001_0000, 0, 4'hF, 32'h0,        32'h3333_3333, 0, 0, 0, 14'h000,  4'h0, 1,  1, 32'h0,         1, 32'h0001_0000};
    vecs[6] = '{32'hDFFF_FFFC, 0, 4'hF, 32'h0,        32'h4444_4444, 0, 0, 0, 14'h000,  4'h0, 1,  1, 32'h0,         1, 32'h0001_0000};
    vecs[7] = '{32'hE100_0000, 1, 4'h0, 32'h5555_5555, 32'h6666_6666, 0, 0, 0, 14'h000,  4'h0, 1,  0, 32'h0,         1, 32'h0001_0000};
    vecs[8] = '{32'hE000_0000, 0, 4'hF, 32'h0,        32'h7777_7777, 0, 1, 0, 14'h000,  4'h0, 256, 1, 32'h0,        1, 32'hE000_0000};
    vecs[9] = '{32'h0000_0008, 1, 4'h8, 32'h7700_0000, 32'h0000_0055, 0, 1, 1, 14'h002,  4'h8, 1,  1, 32'h0000_0055, 0, 32'h0};

    bus.cpu_request = 1'b0; bus.cpu_address = 32'h0; bus.cpu_write = 1'b0; bus.cpu_wstrb = 4'h0;
    bus.cpu_wdata = 32'h0; bus.err_clear = 1'b0; bus.per_ready = 1'b0; bus.per_rdata = 32'h0;
    bus.sram_rdata = 32'h0;
    repeat (2) @(posedge clock);
    #1;

    // Reset state, with an SRAM request pending that must not reach the SRAM
    cycle(1'b1, 32'h0000_0010, 1'b1, 4'hF, 32'h1, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("reset sram_en", obs_en, 1'b0);
    chk("reset cpu_ack", obs_ack, 1'b0);
    rst_n = 1'b1;
    idle(1'b0);

    foreach (vecs[i]) apply_vec(vecs[i]);

    // Back-to-back SRAM: second request issued in the first one's ack cycle
    cycle(1'b1, 32'h10, 1'b0, 4'hF, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    cycle(1'b1, 32'h14, 1'b0, 4'hF, 32'h0, 1'b0, 1'b0, 32'h0, 32'h1234_5678);
    chk("b2b ack1", obs_ack, 1'b1);
    chk("b2b rdata1", obs_rd, 32'h1234_5678);
    chk("b2b sram_en2", obs_en, 1'b1);
    chk("b2b sram_addr2", obs_saddr, 14'h005);
    cycle(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h9ABC_DEF0);
    chk("b2b ack2", obs_ack, 1'b1);
    chk("b2b rdata2", obs_rd, 32'h9ABC_DEF0);
    idle(1'b0);
    chk("b2b no_ack", obs_ack, 1'b0);

    // Two unmapped loads: first address sticks; clear with simultaneous error reloads
    idle(1'b1);
    cycle(1'b1, 32'h8000_0000, 1'b0, 4'hF, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    cycle(1'b1, 32'h9000_0000, 1'b0, 4'hF, 32'h0, 1'b0, 1'b0, 32'h0, 32'hFFFF_FFFF);
    chk("unm ack1", obs_ack, 1'b1);
    chk("unm rdata1", obs_rd, 32'h0);
    chk("unm bus_error", obs_berr, 1'b1);
    chk("unm err_addr1", obs_eaddr, 32'h8000_0000);
    idle(1'b0);
    chk("unm ack2", obs_ack, 1'b1);
    chk("unm rdata2", obs_rd, 32'h0);
    chk("unm err_addr2", obs_eaddr, 32'h8000_0000);
    cycle(1'b1, 32'hF000_0000, 1'b0, 4'hF, 32'h0, 1'b1, 1'b0, 32'h0, 32'h0);
    idle(1'b0);
    chk("clr+err bus_error", obs_berr, 1'b1);
    chk("clr+err err_addr", obs_eaddr, 32'hF000_0000);
    idle(1'b1);
    idle(1'b0);
    chk("clear bus_error", obs_berr, 1'b0);

    // Reset while a peripheral request waits; stray requests meanwhile are ignored
    cycle(1'b1, 32'hE000_0010, 1'b0, 4'hF, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (3) cycle(1'b1, 32'h100, 1'b1, 4'hF, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("rst pre per_valid", obs_pv, 1'b1);
    rst_n = 1'b0;
    cycle(1'b1, 32'h100, 1'b1, 4'hF, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("rst sram_en", obs_en, 1'b0);
    rst_n = 1'b1;
    idle(1'b0);
    chk("rst per_valid", obs_pv, 1'b0);
    chk("rst no_ack", obs_ack, 1'b0);
    cycle(1'b1, 32'h40, 1'b0, 4'hF, 32'h0, 1'b0, 1'b1, 32'h0, 32'h0);
    chk("post-rst sram_en", obs_en, 1'b1);
    cycle(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0F0F_0F0F);
    chk("post-rst ack", obs_ack, 1'b1);
    chk("post-rst rdata", obs_rd, 32'h0F0F_0F0F);

    // Random traffic against the reference model
    for (int i = 0; i < 1200; i++) begin
      rst_n = ($urandom_range(0, 299) != 0);
      cycle($urandom_range(0, 1) == 1, rand_addr(), $urandom_range(0, 1) == 1,
            ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom),
            $urandom, $urandom_range(0, 9) == 0, $urandom_range(0, 2) == 0,
            $urandom, $urandom);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 300 && m_busy; i++)
      cycle(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b0, 1'b1, $urandom, $urandom);
    idle(1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
